// File: rtl/ps2_rx_frame_if.sv
// Host-side read/status bundle of the PS/2 frame receiver.
// The receiver uses the slave modport; the keyboard peripheral uses master.
interface ps2_rx_frame_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rd_en;
  logic          err_clr;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [CW-1:0] fifo_count;
  logic          rx_busy;
  logic          parity_err;
  logic          frame_err;
  logic          overflow;

  modport master (
    output rd_en, err_clr,
    input  rd_data, rd_valid, fifo_count, rx_busy, parity_err, frame_err, overflow
  );

  modport slave (
    input  rd_en, err_clr,
    output rd_data, rd_valid, fifo_count, rx_busy, parity_err, frame_err, overflow
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: pin sync + clock de-glitch, 11-bit frame
// deserialiser, show-ahead scancode FIFO and sticky error flags.
module ps2_rx_frame #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  ps2_rx_frame_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  // ---------------- input conditioning ----------------
  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, fall_q;
  logic [FW-1:0] flt_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      filt_q    <= 1'b1;
      fall_q    <= 1'b0;
      flt_cnt_q <= '0;
    end else begin
      clk_s1_q <= ps2_clk_in;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_dat_in;
      dat_s2_q <= dat_s1_q;
      fall_q   <= 1'b0;
      // Any sample agreeing with the filtered level restarts the run count.
      if (clk_s2_q != filt_q) begin
        if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
          filt_q    <= clk_s2_q;
          fall_q    <= ~clk_s2_q;
          flt_cnt_q <= '0;
        end else begin
          flt_cnt_q <= flt_cnt_q + FW'(1);
        end
      end else begin
        flt_cnt_q <= '0;
      end
    end
  end

  // ---------------- frame FSM ----------------
  state_e        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          perr_q, perr_d;
  logic          push_q, push_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ferr_set, perr_set;
  logic          bit_in;

  assign bit_in = dat_s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      perr_q   <= 1'b0;
      push_q   <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      perr_q   <= perr_d;
      push_q   <= push_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    perr_d   = perr_q;
    push_d   = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    tmo_d    = (state_q == IDLE || fall_q) ? '0 : tmo_q + TW'(1);
    if (fall_q) begin
      case (state_q)
        IDLE: begin
          if (!bit_in) begin
            state_d  = DATA;
            bitcnt_d = '0;
          end else begin
            ferr_set = 1'b1;
          end
        end
        DATA: begin
          shreg_d  = {bit_in, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          perr_d  = ~(^shreg_q ^ bit_in);
          state_d = STOP;
        end
        STOP: begin
          if (!bit_in)     ferr_set = 1'b1;
          else if (!perr_q) push_d  = 1'b1;
          if (perr_q)      perr_set = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d  = IDLE;
      ferr_set = 1'b1;
    end
  end

  // ---------------- scancode FIFO ----------------
  // shreg_q is untouched in IDLE, so it still holds the byte during push_q.
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          empty, full, pop, wr, ovf_set;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = bus.rd_en & ~empty;
  assign wr      = push_q & (~full | pop);
  assign ovf_set = push_q & full & ~pop;

  always_ff @(posedge clk) begin
    if (!reset && wr) mem_q[wptr_q] <= shreg_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr)  wptr_q <= wptr_q + AW'(1);
      if (pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(wr) - CW'(pop);
    end
  end

  // ---------------- sticky flags ----------------
  logic perr_flag_q, ferr_flag_q, ovf_flag_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perr_flag_q <= 1'b0;
      ferr_flag_q <= 1'b0;
      ovf_flag_q  <= 1'b0;
    end else begin
      perr_flag_q <= perr_set | (perr_flag_q & ~bus.err_clr);
      ferr_flag_q <= ferr_set | (ferr_flag_q & ~bus.err_clr);
      ovf_flag_q  <= ovf_set  | (ovf_flag_q  & ~bus.err_clr);
    end
  end

  assign bus.rd_data    = empty ? 8'h00 : mem_q[rptr_q];
  assign bus.rd_valid   = ~empty;
  assign bus.fifo_count = count_q;
  assign bus.rx_busy    = (state_q != IDLE);
  assign bus.parity_err = perr_flag_q;
  assign bus.frame_err  = ferr_flag_q;
  assign bus.overflow   = ovf_flag_q;
endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: good/bad frames, timeout, overflow,
// clock glitches and mid-frame reset.
module tb_ps2_rx_frame;
  localparam int HALF = 20;
  localparam int TMO  = 200;
  localparam int FLT  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ps2_rx_frame_if #(.FIFO_DEPTH(8)) bus ();

  ps2_rx_frame #(.FILTER_LEN(FLT), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk),
    .ps2_dat_in (ps2_dat),
    .bus        (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic badpar);
    return {1'b1, (~^d) ^ badpar, d, 1'b0};
  endfunction

  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_dat = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) ps2_bit(f[i]);
    repeat (HALF) @(negedge clk);
    ps2_dat = 1'b1;
  endtask

  task automatic pop();
    @(negedge clk) bus.rd_en = 1'b1;
    @(negedge clk) bus.rd_en = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk) bus.err_clr = 1'b1;
    @(negedge clk) bus.err_clr = 1'b0;
  endtask

  task automatic glitch();
    @(negedge clk) ps2_clk = 1'b0;
    repeat (FLT - 2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  logic [7:0] exp_seq [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

  initial begin
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", bus.rd_valid, 0);
    chk("rst_data",  bus.rd_data, 8'h00);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_busy",  bus.rx_busy, 0);
    chk("rst_flags", {bus.parity_err, bus.frame_err, bus.overflow}, 0);

    // good frame
    send_bits(frame(8'h1C, 1'b0), 0, 10);
    chk("t1_data",  bus.rd_data, 8'h1C);
    chk("t1_valid", bus.rd_valid, 1);
    chk("t1_count", bus.fifo_count, 1);
    chk("t1_flags", {bus.parity_err, bus.frame_err, bus.overflow}, 0);
    pop();
    chk("t1_pop_count", bus.fifo_count, 0);
    chk("t1_pop_valid", bus.rd_valid, 0);

    // bad parity
    send_bits(frame(8'h1C, 1'b1), 0, 10);
    chk("t2_count", bus.fifo_count, 0);
    chk("t2_perr",  bus.parity_err, 1);
    chk("t2_ferr",  bus.frame_err, 0);
    clr();
    chk("t2_clr",   bus.parity_err, 0);

    // timeout mid-frame
    send_bits(frame(8'hAA, 1'b0), 0, 4);
    chk("t3_busy_mid", bus.rx_busy, 1);
    repeat (TMO + 20) @(negedge clk);
    chk("t3_ferr",  bus.frame_err, 1);
    chk("t3_busy",  bus.rx_busy, 0);
    chk("t3_count", bus.fifo_count, 0);
    clr();
    chk("t3_clr",   bus.frame_err, 0);
    send_bits(frame(8'hF0, 1'b0), 0, 10);
    chk("t3_data",  bus.rd_data, 8'hF0);
    chk("t3_ferr2", bus.frame_err, 0);
    pop();

    // overflow
    for (int i = 1; i <= 9; i++) send_bits(frame(8'(i), 1'b0), 0, 10);
    chk("t4_count", bus.fifo_count, 8);
    chk("t4_ovf",   bus.overflow, 1);
    chk("t4_head",  bus.rd_data, 8'h01);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_pop%0d", i), bus.rd_data, exp_seq[i]);
      pop();
    end
    chk("t4_empty", bus.fifo_count, 0);
    clr();
    chk("t4_clr",   bus.overflow, 0);

    // glitches in IDLE and in DATA
    glitch();
    chk("t5_idle_busy", bus.rx_busy, 0);
    chk("t5_idle_ferr", bus.frame_err, 0);
    send_bits(frame(8'h5A, 1'b0), 0, 3);
    glitch();
    chk("t5_data_busy", bus.rx_busy, 1);
    send_bits(frame(8'h5A, 1'b0), 4, 10);
    chk("t5_data",  bus.rd_data, 8'h5A);
    chk("t5_count", bus.fifo_count, 1);
    chk("t5_flags", {bus.parity_err, bus.frame_err, bus.overflow}, 0);
    pop();

    // reset mid-frame
    send_bits(frame(8'h77, 1'b0), 0, 4);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_busy",  bus.rx_busy, 0);
    chk("t6_empty", bus.fifo_count, 0);
    send_bits(frame(8'h29, 1'b0), 0, 10);
    chk("t6_data",  bus.rd_data, 8'h29);
    chk("t6_count", bus.fifo_count, 1);
    chk("t6_flags", {bus.parity_err, bus.frame_err, bus.overflow}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
